ex_mem_stage: RTL
=================

// Module: ex_mem_stage
// PURPOSE
//  EX/MEM pipeline stage directly downstream of the ALU in the KIRA RISC-V core.
//  - Registers the ALU result together with destination/memory control under a
//    valid/ready handshake, with stall and flush support.
//  - Exports an EX->ID forwarding port and a load-pending flag for the hazard unit.
//  - Optionally converts the ALU multiply into a 2-cycle multicycle path.
// PARAMETERS
//  XLEN       32  datapath width (ALU result, store data)
//  RF_ADDR_W  5   register-file address width
// PORTS
//  clk             in   1          clock; all state updates on rising edge
//  rst             in   1          synchronous, active-high reset
//  flush           in   1          kill held and incoming instruction (branch/trap)
//  in_valid        in   1          EX instruction valid
//  in_ready        out  1          stage can accept EX instruction this cycle
//  alu_out         in   XLEN       ALU result (address for load/store)
//  alu_sel         in   4          ALU op of EX instruction (11 = MUL)
//  rd              in   RF_ADDR_W  destination register
//  rd_we           in   1          writes rd
//  mem_re          in   1          load
//  mem_we          in   1          store
//  mem_size        in   2          0 byte, 1 half, 2 word
//  mem_unsigned    in   1          zero-extend load
//  store_data      in   XLEN       rs2 value for stores
//  out_valid       out  1          MEM-side instruction valid
//  out_ready       in   1          MEM stage accepts
//  out_result      out  XLEN       registered alu_out
//  out_rd / out_rd_we / out_mem_re / out_mem_we / out_mem_size / out_mem_unsigned /
//  out_store_data  out  -          registered copies, widths as inputs
//  fwd_valid       out  1          out_valid & out_rd_we & out_rd!=0 & !out_mem_re
//  fwd_rd          out  RF_ADDR_W  = out_rd
//  fwd_data        out  XLEN       = out_result
//  load_pending    out  1          out_valid & out_mem_re & out_rd_we & out_rd!=0
// BEHAVIOUR
//  - Reset: all out_* regs, out_valid, fwd_valid, load_pending = 0; FSM = IDLE.
//  - Handshake: accept = in_valid & in_ready; in_ready = !out_valid | out_ready
//    (further gated by FSM below). Latency 1 cycle: accepted data appears on
//    out_* next cycle with out_valid=1.
//  - Hold: out_valid & !out_ready -> all out_* stable, in_ready=0.
//  - Drain: out_valid & out_ready & !accept -> out_valid=0 next cycle.
//  - rd==0: out_rd_we forced 0 at capture.
//  - mem_re & mem_we both 1: illegal; captured as store (out_mem_re=0).
//  - flush: next-cycle out_valid=0, FSM->IDLE; flush beats simultaneous accept;
//    flush with rst: rst wins (identical result).
//  - Payload regs load only on accept (valid-only clearing on drain/flush).
//  - fwd_* / load_pending are pure functions of registered state (no comb in->out).
// CONFIGURATION
//  Macro KIRA_MUL_MULTICYCLE_EN:
//  - Defined: FSM IDLE/MUL_WAIT. In IDLE, in_valid & alu_sel==11 & !flush
//    -> in_ready=0, go MUL_WAIT (upstream holds operands).
//  - In MUL_WAIT, in_ready = !out_valid | out_ready; on accept capture, ->IDLE.
//  - While out blocked, stays MUL_WAIT. MUL latency in->out = 2 cycles minimum.
//    Multiplier is a 2-cycle multicycle path in STA.
//  - Undefined: no FSM; MUL handled like any op (1 cycle).
// STRUCTURE
//  - Package kira_ex_pkg: ALU_SEL_* localparams (ALU_SEL_MUL=4'd11),
//    typedef mem_size_e {MEM_B, MEM_H, MEM_W}, typedef ex_mem_t packed payload
//    struct, typedef mul_state_e {MUL_IDLE, MUL_WAIT}.
//  - No sub-module; payload reg, valid bit and FSM inline.
// TESTING
//  - Reset: rst=1 two cycles with in_valid=1 -> out_valid=0, fwd_valid=0, load_pending=0.
//  - Back-to-back ADD: 3 ops, out_ready=1 -> one result/cycle, out_result 5,7,9 at
//    cycles 1,2,3; fwd_rd/fwd_data match.
//  - Backpressure: out_ready=0 for 3 cycles with out_valid=1 -> in_ready=0,
//    out_result held at 0x12345678; releases in order, no loss or duplication.
//  - Flush: flush with in_valid=1 -> out_valid=0 next cycle; load rd=5 then flush
//    -> load_pending 1 then 0.
//  - rd=0 ADD -> out_rd_we=0, fwd_valid=0; load rd=3 -> fwd_valid=0, load_pending=1.
//  - KIRA_MUL_MULTICYCLE_EN: MUL alu_out=0x00030000 -> in_ready 0 then 1, out_valid
//    at cycle 2; flush in MUL_WAIT -> IDLE, no output. Undefined: out_valid at cycle 1.

Source files
------------

// File: rtl/kira_ex_pkg.sv
// Shared types and constants for the KIRA EX/MEM boundary: ALU op encodings,
// memory access size, the registered EX/MEM payload and the multiply FSM states.
package kira_ex_pkg;

    localparam int KIRA_XLEN      = 32;
    localparam int KIRA_RF_ADDR_W = 5;

    localparam logic [3:0] ALU_SEL_ADD  = 4'd0;
    localparam logic [3:0] ALU_SEL_SUB  = 4'd1;
    localparam logic [3:0] ALU_SEL_SLL  = 4'd2;
    localparam logic [3:0] ALU_SEL_SLT  = 4'd3;
    localparam logic [3:0] ALU_SEL_SLTU = 4'd4;
    localparam logic [3:0] ALU_SEL_XOR  = 4'd5;
    localparam logic [3:0] ALU_SEL_SRL  = 4'd6;
    localparam logic [3:0] ALU_SEL_SRA  = 4'd7;
    localparam logic [3:0] ALU_SEL_OR   = 4'd8;
    localparam logic [3:0] ALU_SEL_AND  = 4'd9;
    localparam logic [3:0] ALU_SEL_LUI  = 4'd10;
    localparam logic [3:0] ALU_SEL_MUL  = 4'd11;

    typedef enum logic [1:0] {
        MEM_B = 2'd0,
        MEM_H = 2'd1,
        MEM_W = 2'd2
    } mem_size_e;

    // Everything the MEM stage needs about one instruction.
    typedef struct packed {
        logic [KIRA_XLEN-1:0]      result;
        logic [KIRA_RF_ADDR_W-1:0] rd;
        logic                      rd_we;
        logic                      mem_re;
        logic                      mem_we;
        mem_size_e                 mem_size;
        logic                      mem_unsigned;
        logic [KIRA_XLEN-1:0]      store_data;
    } ex_mem_t;

    typedef enum logic {
        MUL_IDLE = 1'b0,
        MUL_WAIT = 1'b1
    } mul_state_e;

endpackage

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register of the KIRA core with valid/ready handshake, flush,
// EX->ID forwarding and a load-pending flag for the hazard unit.
// Optional macro KIRA_MUL_MULTICYCLE_EN: multiply is held one extra cycle in EX
// so the multiplier can be timed as a 2-cycle multicycle path.
// XLEN / RF_ADDR_W must match the package payload widths (KIRA_XLEN, KIRA_RF_ADDR_W).
module ex_mem_stage
    import kira_ex_pkg::*;
#(
    parameter int XLEN      = KIRA_XLEN,
    parameter int RF_ADDR_W = KIRA_RF_ADDR_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [XLEN-1:0]      alu_out,
    input  logic [3:0]           alu_sel,
    input  logic [RF_ADDR_W-1:0] rd,
    input  logic                 rd_we,
    input  logic                 mem_re,
    input  logic                 mem_we,
    input  logic [1:0]           mem_size,
    input  logic                 mem_unsigned,
    input  logic [XLEN-1:0]      store_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      out_result,
    output logic [RF_ADDR_W-1:0] out_rd,
    output logic                 out_rd_we,
    output logic                 out_mem_re,
    output logic                 out_mem_we,
    output logic [1:0]           out_mem_size,
    output logic                 out_mem_unsigned,
    output logic [XLEN-1:0]      out_store_data,
    output logic                 fwd_valid,
    output logic [RF_ADDR_W-1:0] fwd_rd,
    output logic [XLEN-1:0]      fwd_data,
    output logic                 load_pending
);

    ex_mem_t ex_mem_p1;
    logic    vld_p1;
    logic    base_ready;
    logic    accept;
    logic    capture;

    // Build the registered payload: x0 never gets a write enable, and an
    // illegal load+store combination is demoted to a plain store.
    function automatic ex_mem_t capture_payload(
        input logic [XLEN-1:0]      f_alu_out,
        input logic [RF_ADDR_W-1:0] f_rd,
        input logic                 f_rd_we,
        input logic                 f_mem_re,
        input logic                 f_mem_we,
        input logic [1:0]           f_mem_size,
        input logic                 f_mem_unsigned,
        input logic [XLEN-1:0]      f_store_data
    );
        ex_mem_t p;
        p.result       = f_alu_out;
        p.rd           = f_rd;
        p.rd_we        = f_rd_we && (f_rd != '0);
        p.mem_re       = f_mem_re && !f_mem_we;
        p.mem_we       = f_mem_we;
        p.mem_size     = mem_size_e'(f_mem_size);
        p.mem_unsigned = f_mem_unsigned;
        p.store_data   = f_store_data;
        return p;
    endfunction

    assign base_ready = !vld_p1 || out_ready;
    assign accept     = in_valid && in_ready;
    assign capture    = accept && !flush;

`ifdef KIRA_MUL_MULTICYCLE_EN
    mul_state_e state_q;
    mul_state_e state_d;
    logic       mul_hold;

    // A fresh multiply is refused for one cycle while the multiplier settles.
    assign mul_hold = (state_q == MUL_IDLE) && in_valid &&
                      (alu_sel == ALU_SEL_MUL) && !flush;
    assign in_ready = base_ready && !mul_hold;

    // Next-state: wait after a held multiply until it is captured or flushed.
    always_comb begin
        state_d = state_q;
        case (state_q)
            MUL_IDLE: if (mul_hold) state_d = MUL_WAIT;
            MUL_WAIT: if (flush || accept) state_d = MUL_IDLE;
            default:  state_d = MUL_IDLE;
        endcase
    end

    // Multiply FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= MUL_IDLE;
        else     state_q <= state_d;
    end
`else
    logic unused_alu_sel;

    assign unused_alu_sel = ^alu_sel;
    assign in_ready       = base_ready;
`endif

    // Stage boundary EX -> MEM: valid bit, set on capture, cleared on drain/flush.
    always_ff @(posedge clk) begin
        if (rst)            vld_p1 <= 1'b0;
        else if (flush)     vld_p1 <= 1'b0;
        else if (capture)   vld_p1 <= 1'b1;
        else if (out_ready) vld_p1 <= 1'b0;
    end

    // Stage boundary EX -> MEM: payload loads only when an instruction is captured.
    always_ff @(posedge clk) begin
        if (rst)          ex_mem_p1 <= '0;
        else if (capture) ex_mem_p1 <= capture_payload(alu_out, rd, rd_we, mem_re,
                                                       mem_we, mem_size, mem_unsigned,
                                                       store_data);
    end

    assign out_valid        = vld_p1;
    assign out_result       = ex_mem_p1.result;
    assign out_rd           = ex_mem_p1.rd;
    assign out_rd_we        = ex_mem_p1.rd_we;
    assign out_mem_re       = ex_mem_p1.mem_re;
    assign out_mem_we       = ex_mem_p1.mem_we;
    assign out_mem_size     = ex_mem_p1.mem_size;
    assign out_mem_unsigned = ex_mem_p1.mem_unsigned;
    assign out_store_data   = ex_mem_p1.store_data;

    assign fwd_valid    = vld_p1 && ex_mem_p1.rd_we && (ex_mem_p1.rd != '0) && !ex_mem_p1.mem_re;
    assign fwd_rd       = ex_mem_p1.rd;
    assign fwd_data     = ex_mem_p1.result;
    assign load_pending = vld_p1 && ex_mem_p1.mem_re && ex_mem_p1.rd_we && (ex_mem_p1.rd != '0);

endmodule
